// File: rtl/fp_sigmoid_pkg.sv
// fp_sigmoid_pkg
// Shared definitions for the sigmoid output stage: FSM state encoding,
// op-select for the shared arithmetic unit, and the IEEE-754 single
// constants used by the Newton-Raphson reciprocal.
package fp_sigmoid_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADD,
        S_SCALE,
        S_SEED_M,
        S_SEED_A,
        S_NR_M1,
        S_NR_S,
        S_NR_M2,
        S_FIX,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_ADD,
        OP_SUB
    } op_e;

    localparam logic [31:0] FP_ONE   = 32'h3F800000;
    localparam logic [31:0] FP_TWO   = 32'h40000000;
    localparam logic [31:0] SEED_A   = 32'h4034B4B5;
    localparam logic [31:0] SEED_B   = 32'h3FF0F0F1;
    localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
    localparam logic [7:0]  EXP_HALF = 8'd126;

endpackage

// File: rtl/fp_sigmoid_opunit.sv
// fp_sigmoid_opunit
// Shared combinational FP arithmetic for the sigmoid stage: one multiplier
// and one adder, selected by i_op (MUL / ADD / SUB). Both cores round to
// nearest-even, treat denormal operands as zero and flush underflow to zero.
// Ports:
//   i_a, i_b  : IEEE-754 single operands
//   i_op      : operation select
//   o_result  : IEEE-754 single result

module Floating_Point_Multiplier (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_product
);
    logic [47:0] w_prod;
    logic [9:0]  w_exp;
    logic [23:0] w_keep;
    logic [24:0] w_mant;
    logic [22:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_sign;

    // Full 24x24 product, normalise by at most one place, then round to
    // nearest-even using the guard bit and the OR of everything below it.
    always_comb begin
        w_sign = i_a[31] ^ i_b[31];
        w_prod = {24'b0, 1'b1, i_a[22:0]} * {24'b0, 1'b1, i_b[22:0]};
        w_exp  = {2'b00, i_a[30:23]} + {2'b00, i_b[30:23]} - 10'd127;
        if (w_prod[47]) begin
            w_keep   = w_prod[47:24];
            w_guard  = w_prod[23];
            w_sticky = |w_prod[22:0];
            w_exp    = w_exp + 10'd1;
        end else begin
            w_keep   = w_prod[46:23];
            w_guard  = w_prod[22];
            w_sticky = |w_prod[21:0];
        end
        w_mant = {1'b0, w_keep} + {24'b0, w_guard & (w_sticky | w_keep[0])};
        if (w_mant[24]) begin
            w_frac = w_mant[23:1];
            w_exp  = w_exp + 10'd1;
        end else begin
            w_frac = w_mant[22:0];
        end
        if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0 || $signed(w_exp) <= 10'sd0) begin
            o_product = {w_sign, 31'b0};
        end else if ($signed(w_exp) >= 10'sd255) begin
            o_product = {w_sign, 8'hFF, 23'b0};
        end else begin
            o_product = {w_sign, w_exp[7:0], w_frac};
        end
    end
endmodule

module Floating_Point_Adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [7:0]  w_diff;
    logic [26:0] w_mBig;
    logic [53:0] w_ext;
    logic [26:0] w_aligned;
    logic [27:0] w_sum;
    logic [26:0] w_norm;
    logic [4:0]  w_lz;
    logic [9:0]  w_exp;
    logic [24:0] w_round;
    logic [22:0] w_frac;

    // Order operands by magnitude so the result sign is the larger one's,
    // align the smaller with three extra bits (guard, round, sticky),
    // add or subtract, renormalise with a leading-zero count, then round
    // to nearest-even.
    always_comb begin
        if (i_a[30:0] >= i_b[30:0]) begin
            w_big   = i_a;
            w_small = i_b;
        end else begin
            w_big   = i_b;
            w_small = i_a;
        end
        w_diff = w_big[30:23] - w_small[30:23];
        w_mBig = {1'b1, w_big[22:0], 3'b000};
        w_ext  = {1'b1, w_small[22:0], 3'b000, 27'b0} >> w_diff;
        if (w_diff > 8'd26) begin
            w_aligned = 27'd1;
        end else begin
            w_aligned = {w_ext[53:28], |w_ext[27:0]};
        end
        w_exp = {2'b00, w_big[30:23]};
        if (w_big[31] == w_small[31]) begin
            w_sum = {1'b0, w_mBig} + {1'b0, w_aligned};
        end else begin
            w_sum = {1'b0, w_mBig} - {1'b0, w_aligned};
        end
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_sum[i]) begin
                w_lz = 5'(26 - i);
            end
        end
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = w_exp + 10'd1;
        end else begin
            w_norm = w_sum[26:0] << w_lz;
            w_exp  = w_exp - {5'b0, w_lz};
        end
        w_round = {1'b0, w_norm[26:3]} + {24'b0, w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0])};
        if (w_round[24]) begin
            w_frac = w_round[23:1];
            w_exp  = w_exp + 10'd1;
        end else begin
            w_frac = w_round[22:0];
        end
        if (w_small[30:23] == 8'd0) begin
            o_sum = w_big;
        end else if (w_sum == 28'd0) begin
            o_sum = 32'b0;
        end else if ($signed(w_exp) <= 10'sd0) begin
            o_sum = {w_big[31], 31'b0};
        end else if ($signed(w_exp) >= 10'sd255) begin
            o_sum = {w_big[31], 8'hFF, 23'b0};
        end else begin
            o_sum = {w_big[31], w_exp[7:0], w_frac};
        end
    end
endmodule

module fp_sigmoid_opunit
    import fp_sigmoid_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  op_e         i_op,
    output logic [31:0] o_result
);
    logic [31:0] w_addB;
    logic [31:0] w_product;
    logic [31:0] w_sum;

    // Subtraction is addition with the second operand's sign inverted.
    assign w_addB   = (i_op == OP_SUB) ? {~i_b[31], i_b[30:0]} : i_b;
    assign o_result = (i_op == OP_MUL) ? w_product : w_sum;

    Floating_Point_Multiplier u_mul (
        .i_a      (i_a),
        .i_b      (i_b),
        .o_product(w_product)
    );

    Floating_Point_Adder u_add (
        .i_a  (i_a),
        .i_b  (w_addB),
        .o_sum(w_sum)
    );
endmodule

// File: rtl/fp_sigmoid_nr.sv
// fp_sigmoid_nr
// Sigmoid output stage: takes e = e^-x and returns y = 1/(1+e), computing
// the reciprocal by Newton-Raphson on one shared multiplier/adder, one
// operation per cycle. Normal inputs produce out_valid 5+3*NR_ITERS cycles
// after the accept edge; special inputs produce it one cycle after accept.
// Ports:
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : input handshake, exp_in is e (IEEE-754 single)
//   out_valid / out_ready: output handshake, sig_out is y (IEEE-754 single)
//   err                  : exp_in was NaN or negative nonzero

module fp_sigmoid_nr
    import fp_sigmoid_pkg::*;
#(
    parameter int NR_ITERS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sig_out,
    output logic        err
);
    state_e      r_state;
    logic [31:0] r_e;
    logic [31:0] r_d;
    logic [7:0]  r_k;
    logic [31:0] r_t;
    logic [31:0] r_r;
    logic [1:0]  r_iter;
    logic [31:0] r_result;
    logic        r_err;
    logic        r_outValid;
    logic        r_inReady;

    logic [31:0] w_opA;
    logic [31:0] w_opB;
    op_e         w_op;
    logic [31:0] w_opResult;
    logic [9:0]  w_fixExp;

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign sig_out   = r_result;
    assign err       = r_err;

    // Undo the range reduction: 1/d = r * 2^-k, so subtract k from r's
    // exponent field; anything that lands at or below zero is flushed.
    assign w_fixExp = {2'b00, r_r[30:23]} - {2'b00, r_k};

    // Operand steering for the shared arithmetic unit, one op per state.
    always_comb begin
        w_opA = FP_ONE;
        w_opB = r_e;
        w_op  = OP_ADD;
        case (r_state)
            S_SEED_M: begin w_opA = SEED_B; w_opB = r_d; w_op = OP_MUL; end
            S_SEED_A: begin w_opA = SEED_A; w_opB = r_t; w_op = OP_SUB; end
            S_NR_M1:  begin w_opA = r_d;    w_opB = r_r; w_op = OP_MUL; end
            S_NR_S:   begin w_opA = FP_TWO; w_opB = r_t; w_op = OP_SUB; end
            S_NR_M2:  begin w_opA = r_r;    w_opB = r_t; w_op = OP_MUL; end
            default:  ;
        endcase
    end

    fp_sigmoid_opunit u_opunit (
        .i_a     (w_opA),
        .i_b     (w_opB),
        .i_op    (w_op),
        .o_result(w_opResult)
    );

    // Main sequencer. Special inputs are classified in S_ADD so every
    // output comes from a register; the normal path walks the seed and
    // Newton-Raphson states and then rescales in S_FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_e        <= 32'b0;
            r_d        <= 32'b0;
            r_k        <= 8'b0;
            r_t        <= 32'b0;
            r_r        <= 32'b0;
            r_iter     <= 2'b0;
            r_result   <= 32'b0;
            r_err      <= 1'b0;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_e       <= exp_in;
                        r_inReady <= 1'b0;
                        r_state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (r_e[30:23] == 8'd0) begin
                        r_result   <= FP_ONE;
                        r_err      <= 1'b0;
                        r_outValid <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (r_e[31] || (r_e[30:23] == 8'hFF && r_e[22:0] != 23'd0)) begin
                        r_result   <= FP_QNAN;
                        r_err      <= 1'b1;
                        r_outValid <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (r_e[30:23] == 8'hFF) begin
                        r_result   <= 32'b0;
                        r_err      <= 1'b0;
                        r_outValid <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_d     <= w_opResult;
                        r_state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    r_d     <= {1'b0, EXP_HALF, r_d[22:0]};
                    r_k     <= r_d[30:23] - EXP_HALF;
                    r_iter  <= 2'b0;
                    r_state <= S_SEED_M;
                end
                S_SEED_M: begin
                    r_t     <= w_opResult;
                    r_state <= S_SEED_A;
                end
                S_SEED_A: begin
                    r_r     <= w_opResult;
                    r_state <= S_NR_M1;
                end
                S_NR_M1: begin
                    r_t     <= w_opResult;
                    r_state <= S_NR_S;
                end
                S_NR_S: begin
                    r_t     <= w_opResult;
                    r_state <= S_NR_M2;
                end
                S_NR_M2: begin
                    r_r    <= w_opResult;
                    r_iter <= r_iter + 2'd1;
                    if (r_iter == 2'(NR_ITERS - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_NR_M1;
                    end
                end
                S_FIX: begin
                    if ($signed(w_fixExp) <= 10'sd0) begin
                        r_result <= 32'b0;
                    end else begin
                        r_result <= {1'b0, w_fixExp[7:0], r_r[22:0]};
                    end
                    r_err      <= 1'b0;
                    r_outValid <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
